// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a shared-MAC stereo FIR: captures per-channel samples,
// arbitrates left/right onto one MAC and walks the taps of the sample RAM and coefficient ROM.
module fir_tap_sequencer #(
   parameter int TAPS    = 32,
   parameter int AW      = 5,
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 2,
   parameter int DATA_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              smpl_we,
   output logic [AW:0]       smpl_waddr,
   output logic [DATA_W-1:0] smpl_wdata,
   output logic              rd_en,
   output logic [AW:0]       smpl_raddr,
   output logic [AW-1:0]     coef_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic [1:0]        dout_valid,
   output logic              busy,
   output logic              ovf
);

   // Cycles spent in FLUSH before the sum is final in the first IDLE cycle.
   localparam int FLUSH_N = RD_LAT + MAC_LAT - 1;

   typedef enum logic [1:0] {IDLE, WRITE, RUN, FLUSH} state_t;

   state_t                   state, state_nxt;
   logic                     ch, ch_nxt;
   logic [AW-1:0]            k, k_nxt;
   logic [7:0]               fcnt, fcnt_nxt;
   logic                     take, done;
   logic [1:0]               clr;

   logic [1:0]               pend;
   logic                     last;
   logic signed [DATA_W-1:0] hold [2];
   logic [AW-1:0]            wptr [2];
   logic [AW-1:0]            base;

   logic                     we_d, rd_d, busy_d;
   logic [AW:0]              waddr_d, raddr_d;
   logic [DATA_W-1:0]        wdata_d;
   logic [AW-1:0]            coef_d;
   logic [1:0]               dv_d;
   logic [RD_LAT-1:0]        mac_en_p, mac_clr_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ch    <= 1'b0;
         k     <= '0;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         k     <= k_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Round-robin pointer only moves when both channels actually contend.
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      k_nxt     = k;
      fcnt_nxt  = fcnt;
      take      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (|pend) begin
               state_nxt = WRITE;
               take      = 1'b1;
               ch_nxt    = (&pend) ? ~last : pend[1];
            end
         end
         WRITE: begin
            state_nxt = RUN;
            k_nxt     = '0;
         end
         RUN: begin
            if (k == AW'(TAPS - 1)) begin
               state_nxt = FLUSH;
               fcnt_nxt  = '0;
            end else begin
               k_nxt = k + AW'(1);
            end
         end
         FLUSH: begin
            if (fcnt == 8'(FLUSH_N - 1)) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end else begin
               fcnt_nxt = fcnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      clr = take ? (ch_nxt ? 2'b10 : 2'b01) : 2'b00;
   end

   always_comb begin
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      rd_d    = 1'b0;
      raddr_d = '0;
      coef_d  = '0;
      if (take) begin
         we_d    = 1'b1;
         waddr_d = {ch_nxt, wptr[ch_nxt] - AW'(1)};
         wdata_d = hold[ch_nxt];
      end
      if (state_nxt == RUN) begin
         rd_d    = 1'b1;
         raddr_d = {ch_nxt, base + k_nxt};
         coef_d  = k_nxt;
      end
      dv_d   = done ? (ch ? 2'b10 : 2'b01) : 2'b00;
      busy_d = (state_nxt != IDLE);
   end

   // A strobe landing in the pend-clear cycle keeps its sample pending without flagging loss.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 2'b00;
         ovf  <= 1'b0;
         last <= 1'b1;
         base <= '0;
         for (int c = 0; c < 2; c++) begin
            hold[c] <= '0;
            wptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (din_valid[c]) begin
               hold[c] <= din;
               pend[c] <= 1'b1;
               if (pend[c] && !clr[c])
                  ovf <= 1'b1;
            end else if (clr[c]) begin
               pend[c] <= 1'b0;
            end
         end
         if (take) begin
            base <= wptr[ch_nxt] - AW'(1);
            if (&pend)
               last <= ch_nxt;
         end
         if (state == WRITE)
            wptr[ch] <= base;
      end
   end

   // Output stage p0: registered RAM/ROM controls and status
   always_ff @(posedge clk) begin
      if (rst) begin
         smpl_we    <= 1'b0;
         smpl_waddr <= '0;
         smpl_wdata <= '0;
         rd_en      <= 1'b0;
         smpl_raddr <= '0;
         coef_addr  <= '0;
         dout_valid <= 2'b00;
         busy       <= 1'b0;
      end else begin
         smpl_we    <= we_d;
         smpl_waddr <= waddr_d;
         smpl_wdata <= wdata_d;
         rd_en      <= rd_d;
         smpl_raddr <= raddr_d;
         coef_addr  <= coef_d;
         dout_valid <= dv_d;
         busy       <= busy_d;
      end
   end

   // MAC stage p1..pRD_LAT: align MAC enables with the read data
   always_ff @(posedge clk) begin
      if (rst) begin
         mac_en_p  <= '0;
         mac_clr_p <= '0;
      end else begin
         mac_en_p[0]  <= rd_en;
         mac_clr_p[0] <= rd_en && (coef_addr == '0);
         for (int i = 1; i < RD_LAT; i++) begin
            mac_en_p[i]  <= mac_en_p[i-1];
            mac_clr_p[i] <= mac_clr_p[i-1];
         end
      end
   end

   assign mac_en  = mac_en_p[RD_LAT-1];
   assign mac_clr = mac_clr_p[RD_LAT-1];

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed and random strobes against a timestamped service-schedule
// model, with a behavioural sample RAM, coefficient ROM and MAC checking the final channel sums.
module tb_fir_tap_sequencer;
   localparam int TAPS    = 32;
   localparam int AW      = 5;
   localparam int RD_LAT  = 1;
   localparam int MAC_LAT = 2;
   localparam int SVC     = TAPS + RD_LAT + MAC_LAT;
   localparam int NC      = 16384;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    din_valid;
   logic [23:0]   din;
   logic          smpl_we;
   logic [AW:0]   smpl_waddr;
   logic [23:0]   smpl_wdata;
   logic          rd_en;
   logic [AW:0]   smpl_raddr;
   logic [AW-1:0] coef_addr;
   logic          mac_clr;
   logic          mac_en;
   logic [1:0]    dout_valid;
   logic          busy;
   logic          ovf;

   fir_tap_sequencer #(.TAPS(TAPS), .AW(AW), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
      .smpl_we(smpl_we), .smpl_waddr(smpl_waddr), .smpl_wdata(smpl_wdata),
      .rd_en(rd_en), .smpl_raddr(smpl_raddr), .coef_addr(coef_addr),
      .mac_clr(mac_clr), .mac_en(mac_en), .dout_valid(dout_valid),
      .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic int coef_val(input int k);
      return ((k * 37 + 11) % 61) - 30;
   endfunction

   // External sample RAM, coefficient ROM and MAC around the sequencer
   logic signed [23:0] ram [2*TAPS] = '{default: '0};
   logic signed [23:0] rdat = '0;
   int                 cdat = 0;
   logic signed [63:0] acc = '0;

   always @(posedge clk) begin
      if (smpl_we) ram[smpl_waddr] <= smpl_wdata;
      rdat <= ram[smpl_raddr];
      cdat <= coef_val(int'(coef_addr));
      if (mac_en) acc <= (mac_clr ? 64'sd0 : acc) + rdat * cdat;
   end

   typedef struct packed {
      logic               we;
      logic [AW:0]        waddr;
      logic [23:0]        wdata;
      logic               rd;
      logic [AW:0]        raddr;
      logic [AW-1:0]      coef;
      logic               men;
      logic               mclr;
      logic [1:0]         dv;
      logic               busy;
      logic               ovf;
      logic signed [63:0] sum;
   } exp_t;

   exp_t               ex [NC];
   logic [1:0]         m_pend;
   logic [23:0]        m_hold [2];
   int                 m_ptr [2];
   logic               m_last;
   logic               m_ovf;
   int                 free_at;
   logic signed [23:0] m_mem [2][TAPS];

   int cyc;
   int vectors;
   int errors;

   // Each granted request books its whole service window into the expectation table.
   task automatic model_step(input int n, input logic [1:0] dv, input logic [23:0] d, input logic r);
      int w, a, sel, p;
      logic [1:0] clr;
      logic signed [63:0] sum;
      clr = 2'b00;
      if (r) begin
         for (int m = n + 1; m <= n + 2 * SVC; m++) ex[m] = '0;
         m_pend = 2'b00;
         m_hold[0] = '0;
         m_hold[1] = '0;
         m_ptr[0] = 0;
         m_ptr[1] = 0;
         m_last = 1'b1;
         m_ovf = 1'b0;
         free_at = n + 1;
         return;
      end
      if (n >= free_at && m_pend != 2'b00) begin
         if (m_pend == 2'b11) begin
            sel = m_last ? 0 : 1;
            m_last = sel[0];
         end else begin
            sel = m_pend[1] ? 1 : 0;
         end
         clr[sel] = 1'b1;
         w = n + 1;
         m_ptr[sel] = (m_ptr[sel] + TAPS - 1) % TAPS;
         p = m_ptr[sel];
         m_mem[sel][p] = m_hold[sel];
         ex[w].we = 1'b1;
         ex[w].waddr = {sel[0], p[AW-1:0]};
         ex[w].wdata = m_hold[sel];
         sum = 0;
         for (int k = 0; k < TAPS; k++) begin
            a = (p + k) % TAPS;
            ex[w+1+k].rd = 1'b1;
            ex[w+1+k].raddr = {sel[0], a[AW-1:0]};
            ex[w+1+k].coef = k[AW-1:0];
            ex[w+1+RD_LAT+k].men = 1'b1;
            sum += coef_val(k) * m_mem[sel][a];
         end
         ex[w+1+RD_LAT].mclr = 1'b1;
         for (int m = w; m < w + SVC; m++) ex[m].busy = 1'b1;
         ex[w+SVC].dv = sel[0] ? 2'b10 : 2'b01;
         ex[w+SVC].sum = sum;
         free_at = w + SVC;
      end
      for (int c = 0; c < 2; c++) begin
         if (dv[c]) begin
            if (m_pend[c] && !clr[c]) m_ovf = 1'b1;
            m_pend[c] = 1'b1;
            m_hold[c] = d;
         end else if (clr[c]) begin
            m_pend[c] = 1'b0;
         end
      end
      ex[n+1].ovf = m_ovf;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h, expected %0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic check_all(input int n);
      check("smpl_we",    64'(smpl_we),    64'(ex[n].we));
      check("smpl_waddr", 64'(smpl_waddr), 64'(ex[n].waddr));
      check("smpl_wdata", 64'(smpl_wdata), 64'(ex[n].wdata));
      check("rd_en",      64'(rd_en),      64'(ex[n].rd));
      check("smpl_raddr", 64'(smpl_raddr), 64'(ex[n].raddr));
      check("coef_addr",  64'(coef_addr),  64'(ex[n].coef));
      check("mac_en",     64'(mac_en),     64'(ex[n].men));
      check("mac_clr",    64'(mac_clr),    64'(ex[n].mclr));
      check("dout_valid", 64'(dout_valid), 64'(ex[n].dv));
      check("busy",       64'(busy),       64'(ex[n].busy));
      check("ovf",        64'(ovf),        64'(ex[n].ovf));
      if (ex[n].dv != 2'b00) check("mac_sum", acc, ex[n].sum);
   endtask

   task automatic tick(input logic [1:0] dv, input logic [23:0] d, input logic r);
      @(posedge clk);
      #1;
      din_valid = dv;
      din = d;
      rst = r;
      model_step(cyc, dv, d, r);
      @(negedge clk);
      if (cyc > 0) check_all(cyc);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(2'b00, 24'h0, 1'b0);
   endtask

   initial begin
      vectors = 0;
      errors = 0;
      cyc = 0;
      for (int i = 0; i < NC; i++) ex[i] = '0;
      for (int c = 0; c < 2; c++)
         for (int t = 0; t < TAPS; t++) m_mem[c][t] = '0;
      free_at = 0;
      rst = 1'b1;
      din_valid = 2'b00;
      din = 24'h0;

      tick(2'b00, 24'h0, 1'b1);
      tick(2'b00, 24'h0, 1'b1);

      // left impulse
      tick(2'b01, 24'h400000, 1'b0);
      idle(45);

      // two simultaneous pairs: left first, then right first
      tick(2'b11, 24'($urandom()), 1'b0);
      idle(80);
      tick(2'b11, 24'($urandom()), 1'b0);
      idle(80);

      // overflow: two left strobes while right is in service, then one on the left grant cycle
      tick(2'b10, 24'($urandom()), 1'b0);
      idle(9);
      tick(2'b01, 24'($urandom()), 1'b0);
      tick(2'b01, 24'($urandom()), 1'b0);
      idle(25);
      tick(2'b01, 24'($urandom()), 1'b0);
      idle(90);

      // reset during RUN tap 10, then a fresh impulse
      tick(2'b01, 24'($urandom()), 1'b0);
      idle(12);
      tick(2'b00, 24'h0, 1'b1);
      idle(50);
      tick(2'b01, 24'h400000, 1'b0);
      idle(45);

      // right pointer wrap
      for (int i = 0; i < 33; i++) begin
         tick(2'b10, 24'($urandom()), 1'b0);
         idle(39);
      end

      // alternating channels, left impulse on its 4th sample
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0)
            tick(2'b01, (i / 2 == 3) ? 24'h400000 : 24'($urandom()), 1'b0);
         else
            tick(2'b10, 24'($urandom()), 1'b0);
         idle(int'($urandom_range(36, 70)));
      end

      // unconstrained random traffic, overflows included
      for (int i = 0; i < 2000; i++)
         tick({($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)}, 24'($urandom()), 1'b0);
      idle(60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
